group_00: RTL and testbench
===========================

// Module: group_00
// PURPOSE
//  Key-generation accelerator ("LC" = level compute) attached to the CPU datapath.
//  On startLC it latches a round count and a 64-bit seed, then runs levels+1 mixing rounds, one per cycle.
//  Each round emits a 32-bit key into an internal queue that drains to keyOut, one entry per cycle.
//  At completion it drives the final 64-bit state to the register file (dataToReg) and pulses incrPC.
// PARAMETERS
//  QDEPTH  8   key queue depth; must be >= 8, the maximum number of rounds
// PORTS
//  clk        in   1   single system clock, rising edge
//  rst        in   1   reset, asynchronous, active-high
//  stop       in   1   1 = freeze FSM, rounds and queue pop (global stall)
//  dataToLC   in   64  seed value, sampled once per operation
//  startLC    in   1   start request (level), honoured only in IDLE
//  levels     in   3   round count minus one (0 -> 1 round, 7 -> 8 rounds)
//  dataToReg  out  64  final state of last completed operation
//  incrPC     out  1   one-cycle completion pulse
//  keyOut     out  32  last key popped from queue (registered)
//  Qempty     out  1   1 = key queue holds no entries
// BEHAVIOUR
//  Reset (async): state=IDLE, S=0, round cnt=0, dataToReg=0, incrPC=0, keyOut=0, queue cleared, Qempty=1.
//  FSM states IDLE, WAIT, RUN, DONE; while stop=1 every register holds, except the async reset.
//  IDLE: startLC=1 -> latch L=levels, go WAIT. levels is ignored outside this edge.
//  WAIT: stay while startLC=1; on the first edge with startLC=0, load S<=dataToLC, r<=0, go RUN.
//  RUN, per edge: hi=S[63:32], lo=S[31:0]
//    k = hi ^ {lo[26:0],lo[31:27]} ^ {29'b0,r}
//    S <= {lo,k}; push k; r<=r+1
//    after round r==L, go DONE
//  DONE (one cycle): dataToReg<=S, incrPC=1 for this cycle only, go IDLE.
//  startLC while not IDLE is ignored. A new op may start the cycle after DONE.
//  Latency: data sample edge + (L+1) RUN edges + 1 DONE edge until incrPC.
//  Queue: FIFO, QDEPTH entries, 3-bit pointers wrap mod QDEPTH, count 0..QDEPTH.
//    Pop when count!=0 and stop=0: keyOut <= head.
//    Push and pop in the same cycle leave count unchanged.
//    Overflow cannot occur (<=8 pushes per op, pops every cycle); a push when full is dropped.
//  Qempty = (count==0), combinational from count.
//  Mid-operation reset aborts immediately; nothing is pushed and incrPC is not asserted.
// STRUCTURE
//  Package group_00_pkg: state enum {IDLE,WAIT,RUN,DONE}, QDEPTH default, function mix_round(S,r)->k.
//  Sub-module group_00_key_fifo (32-bit x QDEPTH sync FIFO with push, pop, count and empty).
//  The top holds the FSM, the S/r/L registers and the output registers.
// TESTING
//  1. Reset held 5 cycles -> Qempty=1, keyOut=0, dataToReg=0, incrPC=0; inputs toggling have no effect.
//  2. levels=0, startLC 2 cycles, then dataToLC=64'hFFF0F0F0F0F0F0FF
//     -> one key 32'hE1EEEF0E pushed; Qempty=0 for 1 cycle; keyOut=E1EEEF0E
//     -> dataToReg=64'hF0F0F0FF_E1EEEF0E; incrPC one cycle.
//  3. levels=7 with any seed -> 8 keys appear on keyOut on consecutive cycles, matching a mix_round
//     software model; exactly one incrPC; Qempty returns to 1.
//  4. stop=1 for 3 cycles mid-RUN -> S, r, queue and keyOut frozen; the result equals the unstalled run,
//     delayed 3 cycles.
//  5. rst asserted mid-RUN -> all outputs reset on the same edge, no incrPC; the next startLC works normally.
//  6. startLC pulsed during RUN and levels changed -> ignored; round count and result unchanged.

Source files
------------

// File: rtl/group_00_pkg.sv
// Shared definitions for the group_00 level-compute key generator.
// Contents:
//   lc_state_t  : controller states
//   QDEPTH_DEF  : default key-queue depth
//   mix_round   : one mixing round, producing a 32-bit key from state S and round index r
package group_00_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } lc_state_t;

  localparam int QDEPTH_DEF = 8;

  // k = hi ^ rotl(lo, 5) ^ r, where hi/lo are the upper/lower halves of S
  function automatic logic [31:0] mix_round(input logic [63:0] s, input logic [2:0] r);
    mix_round = s[63:32] ^ {s[26:0], s[31:27]} ^ {29'b0, r};
  endfunction

endpackage

// File: rtl/group_00_key_fifo.sv
// Synchronous 32-bit key FIFO with QDEPTH entries.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (clears storage and pointers)
//   push       : write pushData this cycle (dropped when full unless a pop frees a slot)
//   pop        : advance the head this cycle (ignored when empty)
//   pushData   : key to write
//   headData   : oldest stored key (valid when not empty)
//   count      : number of stored keys, 0..QDEPTH
//   empty      : count == 0
module group_00_key_fifo #(
  parameter  int QDEPTH = 8,
  localparam int CW     = $clog2(QDEPTH + 1),
  localparam int PW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   pushData,
  output logic [31:0]   headData,
  output logic [CW-1:0] count,
  output logic          empty
);

  logic [31:0]   mem_r [QDEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  // Pointers wrap explicitly so non-power-of-two depths still behave as a ring
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(QDEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  // Accept decisions; a pop in the same cycle makes room for a push into a full queue
  always_comb begin
    pop_ok_s  = 1'b0;
    push_ok_s = 1'b0;
    if (pop && (count_r != {CW{1'b0}})) begin
      pop_ok_s = 1'b1;
    end else begin
      pop_ok_s = 1'b0;
    end
    if (push && ((count_r != CW'(QDEPTH)) || pop_ok_s)) begin
      push_ok_s = 1'b1;
    end else begin
      push_ok_s = 1'b0;
    end
  end

  // Key storage, cleared on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_r[i] <= 32'h0;
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= pushData;
    end
  end

  // Read/write pointers and occupancy count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign headData = mem_r[rd_ptr_r];
  assign count    = count_r;
  assign empty    = (count_r == {CW{1'b0}});

endmodule

// File: rtl/group_00.sv
// Level-compute key generator. On startLC it latches a round count, waits for
// startLC to drop, samples the 64-bit seed, then runs levels+1 mixing rounds,
// one per cycle. Each round pushes its key into a queue that drains to keyOut
// one entry per cycle. The final state goes to dataToReg with a one-cycle incrPC.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   stop       : global stall; all registers hold while high
//   dataToLC   : 64-bit seed, sampled on the edge where startLC drops in WAIT
//   startLC    : start request, honoured only in IDLE
//   levels     : round count minus one, latched on the IDLE start edge
//   dataToReg  : final state of the last completed operation
//   incrPC     : one-cycle completion pulse
//   keyOut     : last key popped from the queue
//   Qempty     : key queue holds no entries
module group_00
  import group_00_pkg::*;
#(
  parameter int QDEPTH = QDEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stop,
  input  logic [63:0] dataToLC,
  input  logic        startLC,
  input  logic [2:0]  levels,
  output logic [63:0] dataToReg,
  output logic        incrPC,
  output logic [31:0] keyOut,
  output logic        Qempty
);

  localparam int CW = $clog2(QDEPTH + 1);

  lc_state_t     state_r;
  lc_state_t     next_state_s;
  logic [63:0]   s_r;
  logic [2:0]    r_r;
  logic [2:0]    l_r;
  logic [63:0]   data_to_reg_r;
  logic          incr_pc_r;
  logic [31:0]   key_out_r;

  logic          latch_l_s;
  logic          load_seed_s;
  logic          run_round_s;
  logic          finish_s;
  logic [31:0]   key_s;
  logic          pop_s;
  logic [31:0]   fifo_head_s;
  logic [CW-1:0] fifo_count_s;
  logic          fifo_empty_s;

  assign key_s = mix_round(s_r, r_r);
  assign pop_s = (fifo_count_s != {CW{1'b0}}) && !stop;

  // Next-state and datapath strobes; stop freezes everything by holding the state
  always_comb begin
    next_state_s = state_r;
    latch_l_s    = 1'b0;
    load_seed_s  = 1'b0;
    run_round_s  = 1'b0;
    finish_s     = 1'b0;
    if (stop) begin
      next_state_s = state_r;
    end else begin
      case (state_r)
        IDLE: begin
          if (startLC) begin
            latch_l_s    = 1'b1;
            next_state_s = WAIT;
          end else begin
            next_state_s = IDLE;
          end
        end
        WAIT: begin
          if (!startLC) begin
            load_seed_s  = 1'b1;
            next_state_s = RUN;
          end else begin
            next_state_s = WAIT;
          end
        end
        RUN: begin
          run_round_s = 1'b1;
          if (r_r == l_r) begin
            next_state_s = DONE;
          end else begin
            next_state_s = RUN;
          end
        end
        DONE: begin
          finish_s     = 1'b1;
          next_state_s = IDLE;
        end
        default: begin
          next_state_s = IDLE;
        end
      endcase
    end
  end

  // Controller state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Mixing state S, round index r and latched round limit L
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_r <= 64'h0;
      r_r <= 3'd0;
      l_r <= 3'd0;
    end else begin
      if (latch_l_s) begin
        l_r <= levels;
      end
      if (load_seed_s) begin
        s_r <= dataToLC;
        r_r <= 3'd0;
      end else if (run_round_s) begin
        s_r <= {s_r[31:0], key_s};
        r_r <= r_r + 3'd1;
      end
    end
  end

  // Result register and completion pulse; the pulse holds with everything else under stop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_to_reg_r <= 64'h0;
      incr_pc_r     <= 1'b0;
    end else if (!stop) begin
      incr_pc_r <= finish_s;
      if (finish_s) begin
        data_to_reg_r <= s_r;
      end
    end
  end

  // Queue drain register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_out_r <= 32'h0;
    end else if (pop_s) begin
      key_out_r <= fifo_head_s;
    end
  end

  group_00_key_fifo #(
    .QDEPTH (QDEPTH)
  ) u_key_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (run_round_s),
    .pop      (pop_s),
    .pushData (key_s),
    .headData (fifo_head_s),
    .count    (fifo_count_s),
    .empty    (fifo_empty_s)
  );

  assign dataToReg = data_to_reg_r;
  assign incrPC    = incr_pc_r;
  assign keyOut    = key_out_r;
  assign Qempty    = fifo_empty_s;

endmodule

// File: tb/tb_group_00.sv
// Self-checking bench for group_00. A reference model computes the key list and
// final state from the seed and round count; expected outputs per cycle are
// derived from how many non-stalled edges have passed since the seed was sampled.
module tb_group_00;

  logic        clk = 1'b0;
  logic        rst;
  logic        stop;
  logic [63:0] dataToLC;
  logic        startLC;
  logic [2:0]  levels;
  logic [63:0] dataToReg;
  logic        incrPC;
  logic [31:0] keyOut;
  logic        Qempty;

  group_00 dut (
    .clk       (clk),
    .rst       (rst),
    .stop      (stop),
    .dataToLC  (dataToLC),
    .startLC   (startLC),
    .levels    (levels),
    .dataToReg (dataToReg),
    .incrPC    (incrPC),
    .keyOut    (keyOut),
    .Qempty    (Qempty)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  localparam int MAXC = 32;
  logic [97:0] obsVec [MAXC];   // {keyOut, incrPC, Qempty, dataToReg}
  int          obsJ   [MAXC];   // non-stalled edges since seed sample
  int          ncap;

  logic [31:0] mKeys [8];
  logic [63:0] mFinal;
  logic [31:0] holdKey;
  logic [63:0] holdReg;

  // Reference: iterate the round rule on plain 32-bit halves
  task automatic model(input logic [63:0] seed, input int L);
    logic [31:0] hi, lo, k;
    hi = seed[63:32];
    lo = seed[31:0];
    for (int r = 0; r <= L; r++) begin
      k = hi ^ ((lo << 5) | (lo >> 27)) ^ 32'(r);
      mKeys[r] = k;
      hi = lo;
      lo = k;
    end
    mFinal = {hi, lo};
  endtask

  // Expected outputs after j effective edges past the seed sample
  function automatic logic [97:0] exp_at(input int j, input int L);
    logic [31:0] k;
    logic [63:0] d;
    logic        inc, emp;
    if (j >= 2) k = mKeys[(j - 2 > L) ? L : j - 2];
    else        k = holdKey;
    inc = (j == L + 2);
    emp = !(j >= 1 && j <= L + 1);
    d   = (j >= L + 2) ? mFinal : holdReg;
    return {k, inc, emp, d};
  endfunction

  // Drive one operation and capture outputs each cycle from the seed-sample edge on
  task automatic run_op(input logic [63:0] seed, input int L, input int stallAt,
                        input int stallLen, input bit glitch);
    int  j;
    bit  st;
    levels   = 3'(L);
    startLC  = 1'b1;
    stop     = 1'b0;
    dataToLC = {$urandom, $urandom};
    @(posedge clk); #1;
    levels = 3'($urandom);
    @(posedge clk); #1;
    startLC  = 1'b0;
    dataToLC = seed;
    @(posedge clk); #1;
    j    = 0;
    ncap = L + 2 + stallLen + 3;
    obsVec[0] = {keyOut, incrPC, Qempty, dataToReg};
    obsJ[0]   = 0;
    dataToLC  = {$urandom, $urandom};
    for (int i = 1; i < ncap; i++) begin
      st   = (stallLen > 0) && (i >= stallAt) && (i < stallAt + stallLen);
      stop = st;
      if (glitch && j <= L) begin
        startLC  = 1'($urandom);
        levels   = 3'($urandom);
        dataToLC = {$urandom, $urandom};
      end else begin
        startLC = 1'b0;
      end
      @(posedge clk); #1;
      if (!st) j++;
      obsVec[i] = {keyOut, incrPC, Qempty, dataToReg};
      obsJ[i]   = j;
    end
    stop    = 1'b0;
    startLC = 1'b0;
  endtask

  task automatic test_reset;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      startLC  = 1'($urandom);
      stop     = 1'($urandom);
      levels   = 3'($urandom);
      dataToLC = {$urandom, $urandom};
      total++;
      if ({keyOut, incrPC, Qempty, dataToReg} !== {32'h0, 1'b0, 1'b1, 64'h0}) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", c,
                 {keyOut, incrPC, Qempty, dataToReg}, {32'h0, 1'b0, 1'b1, 64'h0});
      end
    end
    startLC = 1'b0;
    stop    = 1'b0;
    rst     = 1'b0;
    holdKey = 32'h0;
    holdReg = 64'h0;
    @(posedge clk); #1;
    total++;
    if ({keyOut, incrPC, Qempty, dataToReg} !== {32'h0, 1'b0, 1'b1, 64'h0}) begin
      bad++;
      $display("FAIL reset_release got=%h exp=%h",
               {keyOut, incrPC, Qempty, dataToReg}, {32'h0, 1'b0, 1'b1, 64'h0});
    end
  endtask

  task automatic test_single_round;
    int nEmp0, nInc;
    model(64'hFFF0F0F0F0F0F0FF, 0);
    run_op(64'hFFF0F0F0F0F0F0FF, 0, 0, 0, 1'b0);
    nEmp0 = 0;
    nInc  = 0;
    for (int i = 0; i < ncap; i++) begin
      total++;
      if (obsVec[i] !== exp_at(obsJ[i], 0)) begin
        bad++;
        $display("FAIL single_seq cyc=%0d got=%h exp=%h", i, obsVec[i], exp_at(obsJ[i], 0));
      end
      if (obsVec[i][64] == 1'b0) nEmp0++;
      if (obsVec[i][65] == 1'b1) nInc++;
    end
    total++;
    if (obsVec[2][97:66] !== 32'hE1EEEF0E) begin
      bad++;
      $display("FAIL single_key got=%h exp=%h", obsVec[2][97:66], 32'hE1EEEF0E);
    end
    total++;
    if (obsVec[2][63:0] !== 64'hF0F0F0FF_E1EEEF0E || obsVec[2][65] !== 1'b1) begin
      bad++;
      $display("FAIL single_result got=%h inc=%b exp=%h inc=1", obsVec[2][63:0],
               obsVec[2][65], 64'hF0F0F0FF_E1EEEF0E);
    end
    total++;
    if (nEmp0 != 1 || nInc != 1) begin
      bad++;
      $display("FAIL single_pulses got nonempty=%0d incr=%0d exp 1 and 1", nEmp0, nInc);
    end
    holdKey = mKeys[0];
    holdReg = mFinal;
  endtask

  task automatic test_eight_rounds;
    logic [63:0] seed;
    int nInc;
    seed = {$urandom, $urandom};
    model(seed, 7);
    run_op(seed, 7, 0, 0, 1'b0);
    nInc = 0;
    for (int i = 0; i < ncap; i++) begin
      total++;
      if (obsVec[i] !== exp_at(obsJ[i], 7)) begin
        bad++;
        $display("FAIL eight_seq cyc=%0d got=%h exp=%h", i, obsVec[i], exp_at(obsJ[i], 7));
      end
      if (obsVec[i][65] == 1'b1) nInc++;
    end
    total++;
    if (nInc != 1 || obsVec[ncap-1][64] !== 1'b1) begin
      bad++;
      $display("FAIL eight_end got incr=%0d empty=%b exp incr=1 empty=1", nInc, obsVec[ncap-1][64]);
    end
    holdKey = mKeys[7];
    holdReg = mFinal;
  endtask

  task automatic test_stall;
    logic [63:0] seed;
    seed = {$urandom, $urandom};
    model(seed, 7);
    run_op(seed, 7, 3, 3, 1'b0);
    for (int i = 0; i < ncap; i++) begin
      total++;
      if (obsVec[i] !== exp_at(obsJ[i], 7)) begin
        bad++;
        $display("FAIL stall_seq cyc=%0d got=%h exp=%h", i, obsVec[i], exp_at(obsJ[i], 7));
      end
    end
    // unstalled completion is 9 cycles after the sample; three stalls push it to 12
    total++;
    if (obsVec[12][65] !== 1'b1 || obsVec[11][65] !== 1'b0) begin
      bad++;
      $display("FAIL stall_latency got inc11=%b inc12=%b exp 0 and 1", obsVec[11][65], obsVec[12][65]);
    end
    holdKey = mKeys[7];
    holdReg = mFinal;
  endtask

  task automatic test_reset_mid_run;
    logic [63:0] seed;
    levels   = 3'd7;
    startLC  = 1'b1;
    dataToLC = {$urandom, $urandom};
    @(posedge clk); #1;
    startLC  = 1'b0;
    @(posedge clk); #1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({keyOut, incrPC, Qempty, dataToReg} !== {32'h0, 1'b0, 1'b1, 64'h0}) begin
      bad++;
      $display("FAIL midrst_async got=%h exp=%h",
               {keyOut, incrPC, Qempty, dataToReg}, {32'h0, 1'b0, 1'b1, 64'h0});
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst     = 1'b0;
    holdKey = 32'h0;
    holdReg = 64'h0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      total++;
      if ({keyOut, incrPC, Qempty, dataToReg} !== {32'h0, 1'b0, 1'b1, 64'h0}) begin
        bad++;
        $display("FAIL midrst_quiet cyc=%0d got=%h exp=%h", c,
                 {keyOut, incrPC, Qempty, dataToReg}, {32'h0, 1'b0, 1'b1, 64'h0});
      end
    end
    seed = {$urandom, $urandom};
    model(seed, 4);
    run_op(seed, 4, 0, 0, 1'b0);
    for (int i = 0; i < ncap; i++) begin
      total++;
      if (obsVec[i] !== exp_at(obsJ[i], 4)) begin
        bad++;
        $display("FAIL midrst_next cyc=%0d got=%h exp=%h", i, obsVec[i], exp_at(obsJ[i], 4));
      end
    end
    holdKey = mKeys[4];
    holdReg = mFinal;
  endtask

  task automatic test_ignore_start;
    logic [63:0] seed;
    seed = {$urandom, $urandom};
    model(seed, 3);
    run_op(seed, 3, 0, 0, 1'b1);
    for (int i = 0; i < ncap; i++) begin
      total++;
      if (obsVec[i] !== exp_at(obsJ[i], 3)) begin
        bad++;
        $display("FAIL ignore_seq cyc=%0d got=%h exp=%h", i, obsVec[i], exp_at(obsJ[i], 3));
      end
    end
    holdKey = mKeys[3];
    holdReg = mFinal;
  endtask

  task automatic test_random;
    logic [63:0] seed;
    int L, sAt, sLen;
    bit g;
    for (int n = 0; n < 6; n++) begin
      seed = {$urandom, $urandom};
      L    = int'($urandom_range(0, 7));
      sLen = int'($urandom_range(0, 3));
      sAt  = int'($urandom_range(1, L + 1));
      g    = 1'($urandom);
      model(seed, L);
      run_op(seed, L, sAt, sLen, g);
      for (int i = 0; i < ncap; i++) begin
        total++;
        if (obsVec[i] !== exp_at(obsJ[i], L)) begin
          bad++;
          $display("FAIL random_seq op=%0d L=%0d cyc=%0d got=%h exp=%h", n, L, i,
                   obsVec[i], exp_at(obsJ[i], L));
        end
      end
      holdKey = mKeys[L];
      holdReg = mFinal;
    end
  endtask

  initial begin
    rst      = 1'b1;
    stop     = 1'b0;
    startLC  = 1'b0;
    dataToLC = 64'h0;
    levels   = 3'd0;
    holdKey  = 32'h0;
    holdReg  = 64'h0;
    test_reset;
    test_single_round;
    test_eight_rounds;
    test_stall;
    test_reset_mid_run;
    test_ignore_start;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
